maze_solver: RTL and testbench

Depth-first maze solver that drives `maze_memory` (16×16 grid, 1 bit per cell, 1 = wall, 0 = free). It starts at (0,0), searches for (15,15), and marks every visited cell by writing 1 back into `maze_memory`. It keeps the path as a stack of 2-bit moves. Once solved, it replays the path one move per cycle to the downstream display/output stage.

---
 rtl/maze_solver_pkg.sv | 36 +++
 rtl/maze_stack.sv | 38 +++
 rtl/maze_solver.sv | 244 ++++++++++++++++++++++++
 tb/tb_maze_solver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_solver_pkg.sv
// rtl/maze_solver_pkg.sv - shared direction codes, FSM states and grid constants for the maze solver
package maze_defs;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_START,
    S_CK_START,
    S_MARK,
    S_PICK,
    S_READ,
    S_CHECK,
    S_POP,
    S_DONE,
    S_FAIL,
    S_REPLAY
  } state_t;

  localparam logic [3:0] GRID_MAX = 4'd15;
  localparam logic [3:0] START_X  = 4'd0;
  localparam logic [3:0] START_Y  = 4'd0;
  localparam logic [3:0] GOAL_X   = 4'd15;
  localparam logic [3:0] GOAL_Y   = 4'd15;

  // The encoding pairs up/down and right/left as bitwise complements.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(~d);
  endfunction

endpackage

// File: rtl/maze_stack.sv
// rtl/maze_stack.sv - LIFO of 2-bit moves with a random read port for path replay
module maze_stack #(
  parameter int DEPTH = 256,
  localparam int AW  = $clog2(DEPTH),
  localparam int SPW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [1:0]     push_data,
  output logic [1:0]     top_data,
  input  logic [AW-1:0]  rd_addr,
  output logic [1:0]     rd_data,
  output logic [SPW-1:0] sp,
  output logic           empty
);

  logic [1:0]     mem [DEPTH];
  logic [SPW-1:0] sp_m1;

  assign sp_m1    = sp - 1'b1;
  assign top_data = mem[sp_m1[AW-1:0]];
  assign rd_data  = mem[rd_addr];
  assign empty    = (sp == '0);

  always_ff @(posedge clk) begin
    if (push) mem[sp[AW-1:0]] <= push_data;
  end

  // Only the pointer resets; stale entries above sp are never observed.
  always_ff @(posedge clk) begin
    if (rst)       sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop)  sp <= sp_m1;
  end

endmodule

// File: rtl/maze_solver.sv
// rtl/maze_solver.sv - depth-first 16x16 maze solver with visited marking and path replay
module maze_solver
  import maze_defs::*;
#(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  input  logic       data_out,
  output logic       rd,
  output logic       wr,
  output logic [3:0] x_pos,
  output logic [3:0] y_pos,
  output logic       data_in,
  output logic       done,
  output logic       fail,
  output logic [1:0] move,
  output logic       move_valid,
  output logic [7:0] path_len
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = $clog2(DEPTH + 1);

  state_t         state, state_d;
  logic [3:0]     cur_x, cur_y, cand_x, cand_y;
  logic [3:0]     cur_x_d, cur_y_d, cand_x_d, cand_y_d;
  logic [2:0]     dir, dir_d;  // bit 2 set once all four directions are tried
  logic [AW-1:0]  idx, idx_d;
  logic           rd_d, wr_d, data_in_d, done_d, fail_d, move_valid_d;
  logic [3:0]     x_d, y_d;
  logic [1:0]     move_d;
  logic [7:0]     path_len_d;

  logic           push, pop, empty;
  logic [1:0]     top_data, rd_data;
  logic [AW-1:0]  rd_addr;
  logic [SPW-1:0] sp;
  logic [3:0]     nx, ny, bx, by;
  logic           off_grid;

  assign rd_addr = (state == S_DONE) ? '0 : idx;

  maze_stack #(.DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (dir[1:0]),
    .top_data  (top_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .sp        (sp),
    .empty     (empty)
  );

  always_comb begin
    nx = cur_x;
    ny = cur_y;
    off_grid = 1'b0;
    unique case (dir_t'(dir[1:0]))
      DIR_UP:    begin off_grid = (cur_y == 4'd0);     ny = cur_y - 4'd1; end
      DIR_RIGHT: begin off_grid = (cur_x == GRID_MAX); nx = cur_x + 4'd1; end
      DIR_LEFT:  begin off_grid = (cur_x == 4'd0);     nx = cur_x - 4'd1; end
      DIR_DOWN:  begin off_grid = (cur_y == GRID_MAX); ny = cur_y + 4'd1; end
    endcase
  end

  // Backtracking steps against the move on top of the stack.
  always_comb begin
    bx = cur_x;
    by = cur_y;
    unique case (opposite(dir_t'(top_data)))
      DIR_UP:    by = cur_y - 4'd1;
      DIR_RIGHT: bx = cur_x + 4'd1;
      DIR_LEFT:  bx = cur_x - 4'd1;
      DIR_DOWN:  by = cur_y + 4'd1;
    endcase
  end

  always_comb begin
    state_d      = state;
    cur_x_d      = cur_x;
    cur_y_d      = cur_y;
    cand_x_d     = cand_x;
    cand_y_d     = cand_y;
    dir_d        = dir;
    idx_d        = idx;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    data_in_d    = 1'b0;
    x_d          = x_pos;
    y_d          = y_pos;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    move_d       = move;
    move_valid_d = 1'b0;
    path_len_d   = path_len;
    push         = 1'b0;
    pop          = 1'b0;
    unique case (state)
      S_IDLE: if (start) begin
        cur_x_d = START_X;
        cur_y_d = START_Y;
        dir_d   = 3'd0;
        rd_d    = 1'b1;
        x_d     = START_X;
        y_d     = START_Y;
        state_d = S_RD_START;
      end
      S_RD_START: state_d = S_CK_START;
      S_CK_START: begin
        if (data_out) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          wr_d      = 1'b1;
          data_in_d = 1'b1;
          x_d       = cur_x;
          y_d       = cur_y;
          state_d   = S_MARK;
        end
      end
      S_MARK: begin
        if (cur_x == GOAL_X && cur_y == GOAL_Y) begin
          done_d     = 1'b1;
          path_len_d = 8'(sp);
          state_d    = S_DONE;
        end else begin
          dir_d   = 3'd0;
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (dir[2]) begin
          state_d = S_POP;
        end else if (off_grid) begin
          dir_d = dir + 3'd1;
        end else begin
          cand_x_d = nx;
          cand_y_d = ny;
          rd_d     = 1'b1;
          x_d      = nx;
          y_d      = ny;
          state_d  = S_READ;
        end
      end
      S_READ: state_d = S_CHECK;
      S_CHECK: begin
        if (!data_out) begin
          push      = 1'b1;
          cur_x_d   = cand_x;
          cur_y_d   = cand_y;
          wr_d      = 1'b1;
          data_in_d = 1'b1;
          x_d       = cand_x;
          y_d       = cand_y;
          state_d   = S_MARK;
        end else if (dir[1:0] == 2'b11) begin
          state_d = S_POP;
        end else begin
          dir_d   = dir + 3'd1;
          state_d = S_PICK;
        end
      end
      S_POP: begin
        if (empty) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          pop     = 1'b1;
          cur_x_d = bx;
          cur_y_d = by;
          dir_d   = {1'b0, top_data} + 3'd1;
          state_d = S_PICK;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (run && !empty) begin
          move_d       = rd_data;
          move_valid_d = 1'b1;
          idx_d        = AW'(1);
          state_d      = S_REPLAY;
        end
      end
      S_REPLAY: begin
        done_d = 1'b1;
        if (SPW'(idx) == sp) begin
          state_d = S_DONE;
        end else begin
          move_d       = rd_data;
          move_valid_d = 1'b1;
          idx_d        = idx + 1'b1;
        end
      end
      S_FAIL: fail_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_x      <= START_X;
      cur_y      <= START_Y;
      cand_x     <= 4'd0;
      cand_y     <= 4'd0;
      dir        <= 3'd0;
      idx        <= '0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      data_in    <= 1'b0;
      x_pos      <= 4'd0;
      y_pos      <= 4'd0;
      done       <= 1'b0;
      fail       <= 1'b0;
      move       <= 2'b00;
      move_valid <= 1'b0;
      path_len   <= 8'd0;
    end else begin
      state      <= state_d;
      cur_x      <= cur_x_d;
      cur_y      <= cur_y_d;
      cand_x     <= cand_x_d;
      cand_y     <= cand_y_d;
      dir        <= dir_d;
      idx        <= idx_d;
      rd         <= rd_d;
      wr         <= wr_d;
      data_in    <= data_in_d;
      x_pos      <= x_d;
      y_pos      <= y_d;
      done       <= done_d;
      fail       <= fail_d;
      move       <= move_d;
      move_valid <= move_valid_d;
      path_len   <= path_len_d;
    end
  end

endmodule

// File: tb/tb_maze_solver.sv
// tb/tb_maze_solver.sv - self-checking bench for maze_solver against a plain DFS reference
module tb_maze_solver;

  logic       clk = 1'b0;
  logic       rst, start, run;
  logic       data_out = 1'b0;
  logic       rd, wr, data_in, done, fail, move_valid;
  logic [3:0] x_pos, y_pos;
  logic [1:0] move;
  logic [7:0] path_len;

  int checks = 0;
  int failures = 0;
  int overlap = 0;
  int din_bad = 0;

  logic       map_q [256];
  logic       mem   [256];
  logic [8:0] dut_trace [$];
  logic [8:0] m_trace   [$];
  logic [1:0] m_path    [$];
  bit         m_mem     [256];
  bit         m_solved;

  always #5 clk = ~clk;

  maze_solver #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run        (run),
    .data_out   (data_out),
    .rd         (rd),
    .wr         (wr),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .data_in    (data_in),
    .done       (done),
    .fail       (fail),
    .move       (move),
    .move_valid (move_valid),
    .path_len   (path_len)
  );

  // Map memory: reloads on reset, one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= map_q[i];
    end else begin
      if (wr) mem[{y_pos, x_pos}] <= data_in;
      if (rd) data_out <= mem[{y_pos, x_pos}];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      dut_trace.delete();
    end else if (rd || wr) begin
      dut_trace.push_back({wr, y_pos, x_pos});
      if (rd && wr) overlap++;
      if (wr && data_in !== 1'b1) din_bad++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dx(input int d);
    return (d == 1) ? 1 : (d == 2) ? -1 : 0;
  endfunction

  function automatic int dy(input int d);
    return (d == 0) ? -1 : (d == 3) ? 1 : 0;
  endfunction

  // Reference search: try up, right, left, down in order; walls and marked cells block.
  task automatic model_run();
    int  cx, cy, d, nx, ny, top;
    bit  advanced;
    m_trace.delete();
    m_path.delete();
    m_solved = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = map_q[i];
    m_trace.push_back(9'h000);
    if (m_mem[0]) return;
    cx = 0;
    cy = 0;
    forever begin
      m_mem[cy * 16 + cx] = 1'b1;
      m_trace.push_back({1'b1, 4'(cy), 4'(cx)});
      if (cx == 15 && cy == 15) begin
        m_solved = 1'b1;
        return;
      end
      d = 0;
      advanced = 1'b0;
      while (!advanced) begin
        if (d > 3) begin
          if (m_path.size() == 0) return;
          top = int'(m_path.pop_back());
          cx -= dx(top);
          cy -= dy(top);
          d = top + 1;
        end else begin
          nx = cx + dx(d);
          ny = cy + dy(d);
          if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
            d++;
          end else begin
            m_trace.push_back({1'b0, 4'(ny), 4'(nx)});
            if (!m_mem[ny * 16 + nx]) begin
              m_path.push_back(2'(d));
              cx = nx;
              cy = ny;
              advanced = 1'b1;
            end else begin
              d++;
            end
          end
        end
      end
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_rd"}, 32'(rd), 0);
    chk({p, "_wr"}, 32'(wr), 0);
    chk({p, "_data_in"}, 32'(data_in), 0);
    chk({p, "_xy"}, {24'd0, y_pos, x_pos}, 0);
    chk({p, "_done_fail"}, {30'd0, done, fail}, 0);
    chk({p, "_move"}, {29'd0, move_valid, move}, 0);
    chk({p, "_path_len"}, 32'(path_len), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic replay(input string name);
    int bad = 0;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < m_path.size(); i++) begin
      if (move_valid !== 1'b1 || move !== m_path[i]) bad++;
      tick();
    end
    chk({name, "_replay_moves"}, bad, 0);
    chk({name, "_replay_end_valid"}, 32'(move_valid), 0);
    chk({name, "_replay_done"}, 32'(done), 1);
  endtask

  task automatic run_case(input string name, input int exp_len, input int exp_solved, output int cyc);
    bit finished = 1'b0;
    bit goal_prev = 1'b0;
    bit goal_seen = 1'b0;
    int nmis = 0;
    int nmem = 0;
    model_run();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!finished && cyc < 30000) begin
      tick();
      cyc++;
      if (goal_prev) chk({name, "_done_after_goal_mark"}, 32'(done), 1);
      goal_prev = wr && x_pos == 4'd15 && y_pos == 4'd15;
      if (goal_prev) goal_seen = 1'b1;
      finished = done || fail;
    end
    chk({name, "_finished"}, 32'(finished), 1);
    if (exp_solved >= 0) chk({name, "_directed_done"}, 32'(done), 32'(exp_solved));
    chk({name, "_done"}, 32'(done), 32'(m_solved));
    chk({name, "_fail"}, 32'(fail), 32'(!m_solved));
    chk({name, "_goal_mark"}, 32'(goal_seen), 32'(m_solved));
    if (m_solved) chk({name, "_path_len"}, 32'(path_len), m_path.size());
    if (exp_len >= 0) chk({name, "_directed_len"}, 32'(path_len), 32'(exp_len));
    chk({name, "_trace_len"}, dut_trace.size(), m_trace.size());
    for (int i = 0; i < dut_trace.size() && i < m_trace.size(); i++)
      if (dut_trace[i] !== m_trace[i]) nmis++;
    chk({name, "_trace"}, nmis, 0);
    for (int i = 0; i < 256; i++)
      if (mem[i] !== m_mem[i]) nmem++;
    chk({name, "_marks"}, nmem, 0);
    if (m_solved && m_path.size() > 0) begin
      replay({name, "_r1"});
      tick();
      replay({name, "_r2"});
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 256; i++) map_q[i] = 1'b0;
    tick();
    tick();
    check_reset("por");
    rst = 1'b0;

    run_case("free", -1, 1, cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("start_in_done_ignored", {30'd0, done, rd}, 32'b10);

    map_q[0] = 1'b1;
    run_case("walled", -1, 0, cyc);
    chk("walled_latency", 32'(cyc <= 4), 1);
    chk("walled_no_write", dut_trace.size(), 1);
    repeat (3) tick();
    chk("walled_fail_holds", 32'(fail), 1);

    for (int i = 0; i < 256; i++) map_q[i] = 1'b0;
    map_q[15 * 16 + 14] = 1'b1;
    map_q[14 * 16 + 15] = 1'b1;
    run_case("enclosed", -1, 0, cyc);

    for (int i = 0; i < 256; i++) map_q[i] = 1'b1;
    for (int x = 0; x <= 5; x++)  map_q[x] = 1'b0;
    for (int y = 0; y < 16; y++)  map_q[y * 16] = 1'b0;
    for (int x = 0; x < 16; x++)  map_q[15 * 16 + x] = 1'b0;
    run_case("deadend", 30, 1, cyc);

    for (int i = 0; i < 256; i++) map_q[i] = 1'b0;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    run_case("midrst_free", -1, 1, cyc);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 256; i++) map_q[i] = ($urandom_range(0, 99) < 28);
      map_q[0] = 1'b0;
      map_q[255] = 1'b0;
      run_case($sformatf("rand%0d", k), -1, -1, cyc);
    end

    chk("rd_wr_overlap", overlap, 0);
    chk("data_in_on_wr", din_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
